// File: rtl/bcd_counter_multi_pkg.sv
// Shared BCD types, limits and digit-validity helpers for the multi-digit counter.
package bcd_counter_multi_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // A nibble is a legal BCD digit when it is 0..9.
  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

  // True when the low n nibbles of w are all legal BCD digits.
  function automatic logic bcd_packed_valid(input logic [31:0] w, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!bcd_valid(w[4*i +: 4])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: clear, validated load, and up/down step with 9<->0 rollover.
module bcd_digit
  import bcd_counter_multi_pkg::*;
#(
  parameter bcd_digit_t INIT_VAL = BCD_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       clr,
  output bcd_digit_t value,
  output logic       is9,
  output logic       is0
);

  bcd_digit_t value_q;
  bcd_digit_t value_d;

  assign value = value_q;
  assign is9   = (value_q == BCD_MAX);
  assign is0   = (value_q == BCD_MIN);

  // Next digit value: clear beats load beats step; an illegal load nibble lands as 0.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = BCD_MIN;
    end else if (ld) begin
      value_d = bcd_valid(ld_val) ? ld_val : BCD_MIN;
    end else if (step) begin
      if (up) value_d = is9 ? BCD_MIN : value_q + 4'd1;
      else    value_d = is0 ? BCD_MAX : value_q - 4'd1;
    end
  end

  // Digit state register with asynchronous reset to the digit's initial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= INIT_VAL;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit up/down BCD counter with cascade enable, clear, validated load,
// combinational terminal count and registered wrap / load-error pulses.
module bcd_counter_multi
  import bcd_counter_multi_pkg::*;
#(
  parameter int                  DIGITS = 4,
  parameter logic [4*DIGITS-1:0] INIT   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cin,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  // Reject unsupported widths and non-BCD reset values when the design is elaborated.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_multi: DIGITS must be 1..8");
  end
  if (!bcd_packed_valid(32'(INIT), DIGITS)) begin : g_bad_init
    $error("bcd_counter_multi: INIT has a nibble above 9");
  end

  logic [DIGITS-1:0] is9_s;
  logic [DIGITS-1:0] is0_s;
  logic [DIGITS-1:0] step_s;
  logic [DIGITS:0]   all9_below;  // bit i: digits 0..i-1 are all 9
  logic [DIGITS:0]   all0_below;  // bit i: digits 0..i-1 are all 0
  logic              count_en;
  logic              bad_nibble;
  logic              wrap_q, wrap_d;
  logic              load_err_q, load_err_d;

  assign count_en = en & cin;

  // Carry/borrow chains: a digit steps only when every lower digit is at its limit.
  always_comb begin
    all9_below[0] = 1'b1;
    all0_below[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9_below[i+1] = all9_below[i] & is9_s[i];
      all0_below[i+1] = all0_below[i] & is0_s[i];
    end
  end

  // Flags a load word containing any nibble above 9.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) bad_nibble = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign step_s[gi] = count_en & (up ? all9_below[gi] : all0_below[gi]);

    bcd_digit #(
      .INIT_VAL (INIT[4*gi +: 4])
    ) u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step_s[gi]),
      .up     (up),
      .ld     (load),
      .ld_val (load_val[4*gi +: 4]),
      .clr    (clr),
      .value  (count[4*gi +: 4]),
      .is9    (is9_s[gi]),
      .is0    (is0_s[gi])
    );
  end

  // Terminal count is zero-latency so a downstream counter's cin sees it this cycle.
  assign tc = count_en & (up ? all9_below[DIGITS] : all0_below[DIGITS]);

  // Pulse sources: a wrap only happens on a real step, and clear suppresses both.
  always_comb begin
    wrap_d     = ~clr & ~load & tc;
    load_err_d = ~clr & load & bad_nibble;
  end

  // Registered one-cycle wrap and load-error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
Parametrised multi-digit synchronous BCD counter, the next generation of the team's single-digit 0-9 counter. It adds configurable digit count, up/down mode, count enable with cascade input, synchronous clear and parallel load with BCD validation. It also provides a combinational terminal-count output for chaining and registered wrap/error pulses. Used for display counters, event tallies and timers feeding 7-segment decoders.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width = 4*DIGITS
INIT, 0, reset value as packed BCD; each nibble must be 0..9 (elaboration-time check)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  count enable
cin  in  1  cascade enable from a lower counter's tc; tie 1 when unused
up  in  1  1 = count up, 0 = count down
clr  in  1  synchronous clear to all zeros
load  in  1  synchronous parallel load
load_val  in  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0]
count  out  4*DIGITS  packed BCD count; digit 0 is in bits [3:0]
tc  out  1  combinational terminal count: en & cin & (up ? all digits 9 : all digits 0)
wrap  out  1  registered one-cycle pulse on the cycle after the counter wraps
load_err  out  1  registered one-cycle pulse on the cycle after a load containing any nibble >9

Behaviour:
- Reset (rst_n=0, async): count=INIT, wrap=0, load_err=0. Release is synchronous to clk and needs no extra cycles.
- Per-edge priority: clr > load > (en & cin) count step > hold.
- clr: count=0; wrap=0; load_err=0.
- load: each nibble of load_val that is 0..9 is loaded as given. Any nibble >9 loads as 0, and load_err=1 for the next cycle; other nibbles are unaffected. wrap=0.
- Count step, up: digit 0 increments. Digit i>0 steps only when digits 0..i-1 are all 9. A digit at 9 that steps goes to 0. When all digits are 9, the step gives all 0 and wrap=1 next cycle.
- Count step, down: digit 0 decrements. Digit i>0 steps only when digits 0..i-1 are all 0. A digit at 0 that steps goes to 9. When all digits are 0, the step gives all 9 and wrap=1 next cycle.
- Hold (en=0 or cin=0): count is unchanged; wrap=0, load_err=0.
- wrap and load_err are never asserted for two consecutive cycles unless the triggering event repeats.
- tc is purely combinational with zero latency. It is asserted exactly on the cycle in which the next edge will wrap, when no clr/load is pending. Downstream: next_counter.cin = this.tc.
- Changing up mid-count takes effect on the next edge. No illegal states are reachable; count nibbles are always 0..9.
- Reset asserted mid-operation overrides everything immediately (asynchronously).
- Latency: load/clr/step are visible on count 1 cycle after the edge.

Decomposition:
- Shared package: BCD_MAX=4'd9, BCD_MIN=4'd0, the nibble-valid check function, and a bcd_digit_t 4-bit type.
- Sub-module bcd_digit: one nibble register with ports step, up, ld, ld_val, clr. It outputs its value plus is9/is0 flags.
- The top level generates DIGITS instances and forms the lower-digit all-9/all-0 AND chains, tc, wrap and load_err.

Test Plan:
- Reset: DIGITS=4, INIT=16'h0000, rst_n low mid-count at 16'h0456 -> count=16'h0000 immediately, without waiting for a clk edge; wrap=0, load_err=0.
- Up carry: load 16'h0199, en=1, cin=1, up=1, 1 cycle -> count=16'h0200; wrap stays 0.
- Up wrap: load 16'h9998, count 2 cycles -> 9999 then 0000. tc=1 while count is 9999. wrap=1 for exactly one cycle after 0000 appears.
- Down wrap: load 16'h0001, up=0, count 2 cycles -> 0000 then 9999. tc=1 at 0000; wrap pulses once.
- Bad load: load_val=16'h12A5 -> count=16'h1205, load_err=1 for 1 cycle then 0.
- Priority/hold: clr=1 with load=1 and en=1 at count 16'h0042 -> count=0. Then en=1, cin=0 for 3 cycles -> count stays 0 and tc=0.
- Cascade: two DIGITS=2 instances chained via tc->cin, starting from 16'h0099 -> next edge gives 16'h0100. Matches a single DIGITS=4 instance over 200 random cycles.
